// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator behind a two-entry valid/ready skid pipeline.
// Optional macro IMM_GEN_ZIMM_EN enables SYSTEM-opcode (CSR) immediate decoding.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZIMM_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [31:0] imm32;
  logic [2:0]  dec_fmt;
  logic        dec_illegal;
  entry_t      new_entry;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;
  logic   retire;

  // Decode the incoming instruction into a 32-bit signed immediate and format.
  always_comb begin
    imm32       = 32'd0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (in_instr[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: begin
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_fmt = FMT_I;
        end
        7'b0100011: begin
          imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
          dec_fmt = FMT_S;
        end
        7'b1100011: begin
          imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
          dec_fmt = FMT_B;
        end
        7'b0110111, 7'b0010111: begin
          imm32   = {in_instr[31:12], 12'd0};
          dec_fmt = FMT_U;
        end
        7'b1101111: begin
          imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
          dec_fmt = FMT_J;
        end
        7'b0110011, 7'b0001111: begin
          dec_fmt = FMT_NONE;
        end
        7'b1110011: begin
`ifdef IMM_GEN_ZIMM_EN
          // funct3[2] selects the uimm CSR forms; 000 covers ECALL/EBREAK/xRET
          if (in_instr[14]) begin
            imm32   = {27'd0, in_instr[19:15]};
            dec_fmt = FMT_Z;
          end else if (in_instr[13:12] != 2'b00) begin
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_fmt = FMT_I;
          end else begin
            dec_fmt = FMT_NONE;
          end
`else
          dec_fmt = FMT_NONE;
`endif
        end
        default: begin
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  // Widen the immediate to XLEN and form the full entry including the target.
  always_comb begin
    new_entry         = '0;
    new_entry.imm     = XLEN'($signed(imm32));
    new_entry.target  = in_pc + XLEN'($signed(imm32));
    new_entry.pc      = in_pc;
    new_entry.fmt     = dec_fmt;
    new_entry.illegal = dec_illegal;
  end

  assign accept = in_valid & in_ready_q & ~flush;
  assign retire = out_valid_q & out_ready;

  // Skid-buffer next state; the output slot refills from skid before new input.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || retire) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_target  = out_q.target;
  assign out_pc      = out_q.pc;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32); honours IMM_GEN_ZIMM_EN.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_target;
  logic [31:0] out_pc;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_pc(out_pc), .out_fmt(out_fmt),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] imm, input logic [31:0] tgt,
                           input logic [31:0] pc, input logic [2:0] fmt, input logic ill);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".imm"}, out_imm, imm);
    chk({tag, ".target"}, out_target, tgt);
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".fmt"}, {29'd0, out_fmt}, {29'd0, fmt});
    chk({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, ill});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'd0; in_pc = 32'd0;
    tick(); tick();
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.imm", out_imm, 32'd0);
    chk("rst.fmt", {29'd0, out_fmt}, 32'd0);
    rst = 1'b0;
    tick();

    // ADDI x1,x0,-1
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h0;
    tick();
    chk_entry("addi", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 3'd1, 1'b0);
    // JAL -4
    in_instr = 32'hFFDFF0EF; in_pc = 32'h100;
    tick();
    chk_entry("jal", 32'hFFFFFFFC, 32'h000000FC, 32'h100, 3'd5, 1'b0);
    // BEQ +8 then LUI back to back
    in_instr = 32'h00000463; in_pc = 32'h10;
    tick();
    chk_entry("beq", 32'h8, 32'h18, 32'h10, 3'd3, 1'b0);
    in_instr = 32'h123452B7; in_pc = 32'h20;
    tick();
    chk_entry("lui", 32'h12345000, 32'h12345020, 32'h20, 3'd4, 1'b0);
    // SW x1,-4(x2)
    in_instr = 32'hFE112E23; in_pc = 32'h60;
    tick();
    chk_entry("sw", 32'hFFFFFFFC, 32'h5C, 32'h60, 3'd2, 1'b0);
    // CSRRWI x0, mstatus, 5
    in_instr = 32'h3002D073; in_pc = 32'h40;
    tick();
`ifdef IMM_GEN_ZIMM_EN
    chk_entry("csrrwi", 32'h5, 32'h45, 32'h40, 3'd6, 1'b0);
`else
    chk_entry("csrrwi", 32'h0, 32'h40, 32'h40, 3'd0, 1'b0);
`endif
    // All-zero word is illegal (instr[1:0] != 11)
    in_instr = 32'h00000000; in_pc = 32'h50;
    tick();
    chk_entry("zero", 32'h0, 32'h50, 32'h50, 3'd0, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: three back-to-back entries while downstream stalls
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
    tick();
    chk_entry("bp.a", 32'h1, 32'h201, 32'h200, 3'd1, 1'b0);
    chk("bp.c1.in_ready", {31'd0, in_ready}, 32'd1);
    in_instr = 32'h00200093; in_pc = 32'h204;
    tick();
    chk("bp.c2.in_ready", {31'd0, in_ready}, 32'd0);
    chk_entry("bp.a.hold", 32'h1, 32'h201, 32'h200, 3'd1, 1'b0);
    in_instr = 32'h00300093; in_pc = 32'h208;
    tick();
    chk("bp.c3.in_ready", {31'd0, in_ready}, 32'd0);
    chk_entry("bp.a.hold2", 32'h1, 32'h201, 32'h200, 3'd1, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_entry("bp.b", 32'h2, 32'h206, 32'h204, 3'd1, 1'b0);
    chk("bp.c4.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_entry("bp.c", 32'h3, 32'h20B, 32'h208, 3'd1, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("bp.drain.valid", {31'd0, out_valid}, 32'd0);

    // Flush with both slots full (a concurrent in_valid must be ignored)
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00400093; in_pc = 32'h300;
    tick();
    in_instr = 32'h00500093; in_pc = 32'h304;
    tick();
    chk("fl.full.in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; in_instr = 32'h00600093; in_pc = 32'h308;
    tick();
    chk("fl.valid", {31'd0, out_valid}, 32'd0);
    chk("fl.in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl.after.valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1; in_instr = 32'h00700093; in_pc = 32'h400;
    tick();
    chk_entry("fl.recover", 32'h7, 32'h407, 32'h400, 3'd1, 1'b0);
    in_valid = 1'b0;
    tick();

    // Reset with both slots full, concurrent flush and input
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00800093; in_pc = 32'h500;
    tick();
    in_instr = 32'hFFDFF0EF; in_pc = 32'h504;
    tick();
    chk("rs.full.in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; flush = 1'b1; in_instr = 32'h00900093; in_pc = 32'h508;
    tick();
    chk("rs.valid", {31'd0, out_valid}, 32'd0);
    chk("rs.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rs.imm", out_imm, 32'd0);
    chk("rs.target", out_target, 32'd0);
    chk("rs.pc", out_pc, 32'd0);
    chk("rs.fmt", {29'd0, out_fmt}, 32'd0);
    chk("rs.illegal", {31'd0, out_illegal}, 32'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs.after.valid", {31'd0, out_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  discard all buffered entries.
REQ-005 SHALL have port in_valid  input  1  upstream entry present.
REQ-006 SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-007 SHALL have port in_instr  input  32  RV32 instruction word.
REQ-008 SHALL have port in_pc  input  XLEN  instruction address.
REQ-009 SHALL have port out_valid  output  1  decoded entry present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the entry.
REQ-011 SHALL have port out_imm  output  XLEN  sign- or zero-extended immediate.
REQ-012 SHALL have port out_target  output  XLEN  in_pc + imm, modulo 2^XLEN.
REQ-013 SHALL have port out_pc  output  XLEN  registered copy of in_pc.
REQ-014 SHALL have port out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
REQ-015 SHALL have port out_illegal  output  1  opcode not recognised.

Function
REQ-016 SHALL accept an entry on a cycle with in_valid=1 and in_ready=1, and present it on out_* exactly 1 cycle later.
REQ-017 SHALL hold two entries (output register plus skid register); in_ready SHALL be a registered signal, equal to 1 exactly when the skid register is empty.
REQ-018 SHALL retire an entry on a cycle with out_valid=1 and out_ready=1; when retiring, the skid entry (if any) SHALL move to the output register in the same cycle.
REQ-019 SHALL, when accept and retire coincide with the skid empty, load the new entry into the output register; entries SHALL never be reordered, dropped or duplicated.
REQ-020 SHALL, when an entry is accepted while the output register is held (out_valid=1, out_ready=0), write it to the skid register and drop in_ready on the next cycle.
REQ-021 SHALL keep all out_* signals stable while out_valid=1 and out_ready=0.
REQ-022 SHALL decode opcode 0000011, 0010011 and 1100111 as I: imm = sign-extend instr[31:20].
REQ-023 SHALL decode opcode 0100011 as S: imm = sign-extend {instr[31:25], instr[11:7]}.
REQ-024 SHALL decode opcode 1100011 as B: imm = sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-025 SHALL decode opcode 0110111 and 0010111 as U: imm = sign-extend {instr[31:12], 12'b0} to XLEN.
REQ-026 SHALL decode opcode 1101111 as J: imm = sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}, with no special-case encodings.
REQ-027 SHALL decode opcode 0110011 and 0001111 as fmt NONE, imm 0, legal.
REQ-028 SHALL, for any other opcode or when instr[1:0] != 2'b11, output fmt NONE, imm 0 and out_illegal=1; such an entry SHALL still flow through the handshake normally.
REQ-029 SHALL compute out_target for every format, including NONE (where target equals pc).
REQ-030 SHALL, on a cycle with flush=1, clear both valid bits at the next edge and ignore in_valid in that cycle; in_ready SHALL be 1 in the cycle after the flush.

Reset
REQ-031 SHALL, on a cycle with rst=1, at the next edge set out_valid=0, skid empty, in_ready=1, and set out_imm, out_target, out_pc, out_fmt and out_illegal to 0.
REQ-032 SHALL give rst priority over flush and over any handshake, including an entry in flight mid-transfer.

Configuration
REQ-033 SHALL, when the macro IMM_GEN_ZIMM_EN is defined, decode opcode 1110011 as follows: funct3[2]=1 gives fmt Z with imm = zero-extend instr[19:15]; funct3 001/010/011 gives fmt I with imm = sign-extend instr[31:20]; funct3 000 gives fmt NONE with imm 0; all three cases are legal.
REQ-034 SHALL, when IMM_GEN_ZIMM_EN is not defined, decode opcode 1110011 as fmt NONE, imm 0, legal; fmt value 6 SHALL never be produced.

Verification
REQ-035 SHALL cover: 0xFFF00093 (ADDI), pc 0x0, out_ready=1 -> 1 cycle later imm 0xFFFFFFFF, fmt 1, target 0xFFFFFFFF.
REQ-036 SHALL cover: 0xFFDFF0EF (JAL -4), pc 0x100 -> imm 0xFFFFFFFC, fmt 5, target 0x000000FC.
REQ-037 SHALL cover: 0x00000463 (BEQ +8), pc 0x10, then 0x123452B7 (LUI) -> imm 0x8, fmt 3, target 0x18; then imm 0x12345000, fmt 4.
REQ-038 SHALL cover: out_ready=0 with 3 back-to-back entries -> 2 accepted, in_ready=0 from cycle 2; on release, entries appear in order and the third is accepted.
REQ-039 SHALL cover: 0x3002D073 (CSRRWI) -> with IMM_GEN_ZIMM_EN: fmt 6, imm 0x5; without it: fmt 0, imm 0; and 0x00000000 -> out_illegal=1.
REQ-040 SHALL cover: flush (and separately rst) with both entries full -> out_valid=0 and in_ready=1 next cycle, and neither entry ever appears on the output.
